hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
//  - Produces stall, flush and forward controls for the decode and execute stages.
//  - Freezes the pipe while a data-memory access in M waits for MemReadyM.
//  - A watchdog latches a sticky error if that wait runs past MEM_TIMEOUT cycles.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive memory-wait stall cycles before error (>=2)
//  TMO_W        5   width of the wait counter; must hold MEM_TIMEOUT
//  CNT_W        32  width of the performance counters
// PORTS
//  clk         in   1      core clock, all state on rising edge
//  rst         in   1      synchronous reset, active-high
//  Rs1D,Rs2D   in   5      source regs of the instruction in D
//  Rs1E,Rs2E   in   5      source regs of the instruction in E
//  RdE,RdM,RdW in   5      destination regs in E/M/W
//  RegWriteM   in   1      M-stage instruction writes the register file
//  RegWriteW   in   1      W-stage instruction writes the register file
//  ResultSrcE  in   2      E-stage result select; 2'b01 = load
//  PCSrcE      in   1      taken branch or jump resolved in E
//  MemReqM     in   1      load/store present in M
//  MemReadyM   in   1      data memory completes the M access this cycle
//  StallF,StallD,StallE,StallM out 1  hold the named pipeline register
//  FlushD,FlushE,FlushW out 1  insert a bubble into the named pipeline register
//  ForwardAE,ForwardBE out 2  00 regfile, 01 ResultW, 10 ALUResultM
//  MemErr      out  1      sticky memory-timeout error
//  StallCnt,FlushCnt out CNT_W  performance counters
// BEHAVIOUR
//  Reset:
//   - While rst=1 every output is 0; state=RUN; wait count=0; MemErr=0; counters=0.
//  Forwarding (combinational, in every state):
//   - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
//   - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E; otherwise 00.
//   - M has priority over W. ForwardBE is identical, using Rs2E.
//  Hazard terms:
//   - memStall = MemReqM && !MemReadyM.
//   - lwStall = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  FSM states: RUN, MEM_WAIT, ERR.
//  RUN:
//   - memStall: StallF=StallD=StallE=StallM=1 and FlushW=1. Next state MEM_WAIT, wait count=1.
//   - Else PCSrcE: FlushD=FlushE=1, StallF=StallD=0. Branch beats lwStall in the same cycle.
//   - Else lwStall: StallF=StallD=1, FlushE=1.
//   - Otherwise all controls 0.
//  MEM_WAIT:
//   - While memStall, the same freeze outputs as RUN; wait count increments.
//   - PCSrcE and lwStall are ignored; E is frozen, so they re-evaluate after release.
//   - MemReadyM=1: freeze drops this same cycle and the RUN rules apply combinationally. Next state RUN, count=0.
//   - Count==MEM_TIMEOUT-1 && memStall: next state ERR.
//   - MemReadyM arriving on that same cycle wins: next state RUN.
//  ERR:
//   - StallF..StallM=1, FlushW=1, MemErr=1.
//   - Only rst exits ERR. Forwarding outputs stay live.
//  Freeze latency:
//   - Maximum freeze is MEM_TIMEOUT cycles; ERR is entered on the cycle after the last one.
//  Reset mid-wait:
//   - The wait is abandoned; the next cycle starts in RUN with all outputs 0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - StallCnt +1 on every cycle with StallD=1.
//   - FlushCnt +1 on every cycle PCSrcE causes a flush.
//   - Both counters saturate at all-ones and clear on rst.
//  HAZARD_PERF_CNT_EN undefined:
//   - Counter logic is removed. StallCnt and FlushCnt are tied to 0; the ports remain.
// TESTING
//  1. RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 -> ForwardAE=01.
//  2. ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. RdE=0 -> no stall.
//  3. PCSrcE=1 together with lwStall -> FlushD=FlushE=1, StallF=0. FlushCnt +1 (macro on).
//  4. MemReqM=1, MemReadyM low 3 cycles then high -> StallF..StallM=FlushW=1 for 3 cycles, released on cycle 4.
//  5. MemReadyM held low, MEM_TIMEOUT=16 -> freeze for 16 cycles, MemErr=1 from cycle 17 until rst.
//  6. rst pulsed in cycle 2 of a memory wait -> all outputs 0 next cycle. A new request with MemReadyM=1 -> no stall.

Source files
------------

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush/forward control for the 5-stage RV32I pipe,
// with a memory-wait freeze, a timeout watchdog and optional perf counters.
// Ports:
//   clk, rst (sync, active-high)
//   Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW      register ids per stage
//   RegWriteM/W, ResultSrcE, PCSrcE        stage controls
//   MemReqM, MemReadyM                     data-memory handshake in M
//   StallF/D/E/M, FlushD/E/W               pipeline register controls
//   ForwardAE/BE                           00 regfile, 01 ResultW, 10 ALUResultM
//   MemErr                                 sticky memory-timeout error
//   StallCnt, FlushCnt                     perf counters
// Build option: define HAZARD_PERF_CNT_EN to implement the perf counters;
// otherwise StallCnt/FlushCnt read as 0.
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_ERR
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_stall;
    logic lw_stall;
    logic freeze;
    logic run_rules;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        run_rules  = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        MemErr     = 1'b0;
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;

        mem_stall = MemReqM && !MemReadyM;
        lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end

        unique case (state_q)
            S_RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = TMO_W'(1);
                end else begin
                    run_rules = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_stall) begin
                    freeze = 1'b1;
                    // The cycle at TMO_LAST is the last allowed freeze cycle.
                    if (wait_cnt_q == TMO_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    // Release is same-cycle: hazards in D/E are re-checked now.
                    run_rules  = 1'b1;
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            end
            S_ERR: begin
                freeze = 1'b1;
                MemErr = 1'b1;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (run_rules) begin
            // A taken branch kills the load-use stalled instruction anyway.
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end

        if (rst) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushW    = 1'b0;
            MemErr    = 1'b0;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // FlushD is raised only by a taken branch, so it marks branch flushes.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushD && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = rst ? '0 : stall_cnt_q;
    assign FlushCnt = rst ? '0 : flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: scoreboard bench for hazard_sequencer; a behavioural
// model queues expected outputs per cycle and a negedge monitor compares.
module tb_hazard_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ResultSrcE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt, FlushCnt;

    hazard_sequencer #(.MEM_TIMEOUT(TMO), .TMO_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sf, sd, se, sm, fd, fe, fw, err;
        logic [1:0]  fa, fb;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    logic bad;

    // Model state: freeze cycles in the current wait, error flag, counters.
    int          m_waited = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic cyc();
        exp_t e;
        bit   ms, lw;
        e  = '0;
        ms = MemReqM && !MemReadyM;
        lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (rst) begin
            m_waited = 0;
            m_err    = 1'b0;
            m_sc     = '0;
            m_fc     = '0;
        end else begin
            e.fa = fwd(Rs1E);
            e.fb = fwd(Rs2E);
`ifdef HAZARD_PERF_CNT_EN
            e.sc = m_sc;
            e.fc = m_fc;
`endif
            if (m_err || ms) begin
                {e.sf, e.sd, e.se, e.sm, e.fw} = '1;
                e.err = m_err;
                if (!m_err) begin
                    m_waited++;
                    if (m_waited == TMO) m_err = 1'b1;
                end
            end else begin
                m_waited = 0;
                if (PCSrcE) begin
                    e.fd = 1'b1;
                    e.fe = 1'b1;
                end else if (lw) begin
                    e.sf = 1'b1;
                    e.sd = 1'b1;
                    e.fe = 1'b1;
                end
            end
            if (e.sd && m_sc != '1) m_sc = m_sc + 1;
            if (e.fd && m_fc != '1) m_fc = m_fc + 1;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    endtask

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        if (a !== x) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, x, $time);
            bad = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            bad = 1'b0;
            chk("StallF", 32'(StallF), 32'(mon_e.sf));
            chk("StallD", 32'(StallD), 32'(mon_e.sd));
            chk("StallE", 32'(StallE), 32'(mon_e.se));
            chk("StallM", 32'(StallM), 32'(mon_e.sm));
            chk("FlushD", 32'(FlushD), 32'(mon_e.fd));
            chk("FlushE", 32'(FlushE), 32'(mon_e.fe));
            chk("FlushW", 32'(FlushW), 32'(mon_e.fw));
            chk("MemErr", 32'(MemErr), 32'(mon_e.err));
            chk("ForwardAE", 32'(ForwardAE), 32'(mon_e.fa));
            chk("ForwardBE", 32'(ForwardBE), 32'(mon_e.fb));
            chk("StallCnt", StallCnt, mon_e.sc);
            chk("FlushCnt", FlushCnt, mon_e.fc);
            vectors++;
            if (bad) miscompares++;
        end
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        rst = 0;
        cyc();
        // Forwarding: M beats W, then W alone.
        RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1; Rs2E = 5;
        cyc();
        RdM = 0;
        cyc();
        idle();
        // Load-use on Rs2D, then RdE=0 gives no stall.
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        cyc();
        idle();
        cyc();
        ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
        cyc();
        // Branch together with load-use.
        RdE = 7; Rs1D = 7; PCSrcE = 1;
        cyc();
        idle();
        cyc();
        // Memory wait 3 cycles, released on the 4th with a load-use pending.
        MemReqM = 1;
        repeat (3) cyc();
        MemReadyM = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        cyc();
        idle();
        // Ready on the last allowed wait cycle still wins.
        MemReqM = 1;
        repeat (TMO - 1) cyc();
        MemReadyM = 1; PCSrcE = 1;
        cyc();
        idle();
        // Full timeout into ERR; branch and ready are ignored there.
        MemReqM = 1;
        repeat (TMO) cyc();
        repeat (3) cyc();
        MemReadyM = 1; PCSrcE = 1; RdM = 9; RegWriteM = 1; Rs2E = 9;
        cyc();
        idle();
        rst = 1;
        cyc();
        rst = 0;
        // Reset in the second cycle of a wait, then a ready request.
        MemReqM = 1;
        cyc();
        rst = 1;
        cyc();
        rst = 0; MemReadyM = 1;
        cyc();
        idle();
        cyc();
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 4) == 0);
            MemReqM    = ($urandom_range(0, 2) == 0) || (i % 300 > 250);
            MemReadyM  = (i % 300 > 250) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc();
        end
        idle();
        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            $display("FAIL drain: %0d expected vectors left, required 0",
                     sbq.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
